bus_uart_tx: RTL and testbench

BUS_UART_TX -- requirements
Module: bus_uart_tx

---
 rtl/bus_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_bus_uart_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter: a DATA register feeding a 4-entry FIFO,
// a STATUS register, and an 8N1 serial shifter with back-to-back framing.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line idle high, waiting for the FIFO to hold a byte
// START | start bit (tx=0) held for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, each held CLKS_PER_BIT cycles
// STOP  | stop bit (tx=1); at its end pop the next byte or go idle
module bus_uart_tx #(
    parameter int          CLKS_PER_BIT = 4,
    parameter logic [7:0]  BASE         = 8'h0E
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic [7:0] data_out,
    output logic       rd_hit,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [7:0] STATUS_ADDR = BASE + 8'd1;
    localparam logic [7:0] BIT_LAST    = 8'(CLKS_PER_BIT - 1);

    state_t     state, state_next;
    logic [7:0] fifo_mem [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] count;
    logic       overflow;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] clk_cnt, clk_cnt_next;
    logic [2:0] bit_idx, bit_idx_next;
    logic       tx_next, busy_next;
    logic       empty, full, push_req, push_ok, pop, bit_end, ovf_clear;

    assign empty     = (count == 3'd0);
    assign full      = (count == 3'd4);
    assign push_req  = write && (address == BASE);
    // A full FIFO still takes the byte if the transmitter frees a slot on the same edge.
    assign push_ok   = push_req && (!full || pop);
    assign ovf_clear = write && (address == STATUS_ADDR) && data_in[3];
    assign bit_end   = (clk_cnt == BIT_LAST);
    assign rd_hit    = (address == BASE) || (address == STATUS_ADDR);

    // Read mux: only STATUS returns data; DATA is write-only.
    always_comb begin
        data_out = 8'h00;
        if (address == STATUS_ADDR)
            data_out = {4'b0000, overflow, busy, full, empty};
    end

    // FIFO storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            fifo_mem[wr_ptr] <= data_in;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push_ok} - {2'b00, pop};
            if (push_req && !push_ok)
                overflow <= 1'b1;
            else if (ovf_clear)
                overflow <= 1'b0;
        end
    end

    // Transmit FSM state and registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            shift_reg <= 8'h00;
            clk_cnt   <= 8'd0;
            bit_idx   <= 3'd0;
        end else begin
            state     <= state_next;
            tx        <= tx_next;
            busy      <= busy_next;
            shift_reg <= shift_next;
            clk_cnt   <= clk_cnt_next;
            bit_idx   <= bit_idx_next;
        end
    end

    // Next-state logic; tx/busy are computed here so they leave the block registered.
    always_comb begin
        state_next   = state;
        tx_next      = tx;
        busy_next    = busy;
        shift_next   = shift_reg;
        clk_cnt_next = clk_cnt + 8'd1;
        bit_idx_next = bit_idx;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_next = 8'd0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr];
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_next = 8'd0;
                    bit_idx_next = 3'd0;
                    tx_next      = shift_reg[0];
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_next = 8'd0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        tx_next      = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_next = 8'd0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr];
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Testbench for bus_uart_tx: expected bytes are queued as they are written,
// and a line monitor decodes frames from tx and checks them against the queue.
module tb_bus_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] address = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       write = 1'b0;
    logic [7:0] data_out;
    logic       rd_hit;
    logic       tx;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    int         frames_done = 0;
    int         cyc = 0;

    bus_uart_tx #(.CLKS_PER_BIT(CPB), .BASE(8'h0E)) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .write(write), .data_out(data_out), .rd_hit(rd_hit), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Line monitor: decodes frames at the falling edge, aborts on reset.
    int         m_phase = 0;
    int         m_cnt = 0;
    int         m_bit = 0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_exp;
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (tx == 1'b0) begin
                    m_phase = 1;
                    m_cnt = 1;
                    starts.push_back(cyc);
                    check(busy == 1'b1, "busy_at_start", int'(busy), 1);
                end
                1: begin
                    check(tx == 1'b0, "start_bit", int'(tx), 0);
                    m_cnt++;
                    if (m_cnt == CPB) begin
                        m_phase = 2;
                        m_cnt = 0;
                        m_bit = 0;
                    end
                end
                2: begin
                    if (m_cnt == 0)
                        m_byte[m_bit] = tx;
                    else
                        check(tx == m_byte[m_bit], "data_hold", int'(tx), int'(m_byte[m_bit]));
                    m_cnt++;
                    if (m_cnt == CPB) begin
                        m_cnt = 0;
                        m_bit++;
                        if (m_bit == 8)
                            m_phase = 3;
                    end
                end
                default: begin
                    check(tx == 1'b1, "stop_bit", int'(tx), 1);
                    check(busy == 1'b1, "busy_in_stop", int'(busy), 1);
                    m_cnt++;
                    if (m_cnt == CPB) begin
                        check(exp_q.size() > 0, "unexpected_frame", int'(m_byte), 0);
                        if (exp_q.size() > 0) begin
                            m_exp = exp_q.pop_front();
                            check(m_byte == m_exp, "frame_byte", int'(m_byte), int'(m_exp));
                        end
                        frames_done++;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        write   = 1'b1;
        @(posedge clk);
        #1;
        write   = 1'b0;
        address = 8'h00;
    endtask

    task automatic check_status(input logic [7:0] exp, input string name);
        address = 8'h0F;
        #1;
        check(data_out == exp, name, int'(data_out), int'(exp));
        address = 8'h00;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (frames_done < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check(frames_done >= n, "frame_timeout", frames_done, n);
        check(exp_q.size() == 0, "pending_bytes", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int fd;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check(tx == 1'b1, "reset_tx", int'(tx), 1);
        check(busy == 1'b0, "reset_busy", int'(busy), 0);
        check_status(8'h01, "reset_status");

        // Single byte 0xA5: tx low exactly one edge after the write edge, 40-cycle frame
        base = frames_done;
        exp_q.push_back(8'hA5);
        do_write(8'h0E, 8'hA5);
        check(tx == 1'b1, "latency_early", int'(tx), 1);
        @(posedge clk); #1;
        check(tx == 1'b0, "latency_tx", int'(tx), 0);
        check(busy == 1'b1, "latency_busy", int'(busy), 1);
        repeat (39) @(posedge clk);
        #1;
        check(tx == 1'b1, "a5_last_stop", int'(tx), 1);
        check(busy == 1'b1, "a5_busy_end", int'(busy), 1);
        @(posedge clk); #1;
        check(busy == 1'b0, "a5_idle_busy", int'(busy), 0);
        wait_frames(base + 1, 100);

        // Back-to-back 0x01, 0x80: no gap between frames
        base = frames_done;
        fd = starts.size();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        do_write(8'h0E, 8'h01);
        do_write(8'h0E, 8'h80);
        wait_frames(base + 2, 200);
        if (starts.size() >= fd + 2)
            check(starts[fd+1] - starts[fd] == 40, "b2b_gap", starts[fd+1] - starts[fd], 40);
        else
            check(starts.size() >= fd + 2, "b2b_starts", starts.size(), fd + 2);
        check_status(8'h01, "b2b_status");

        // Overflow: six stores during START, sixth dropped
        base = frames_done;
        fd = starts.size();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        do_write(8'h0E, 8'h11);
        do_write(8'h0E, 8'h22);
        do_write(8'h0E, 8'h33);
        do_write(8'h0E, 8'h44);
        do_write(8'h0E, 8'h55);
        do_write(8'h0E, 8'h66);
        check_status(8'h0E, "ovf_status_set");
        do_write(8'h0F, 8'h08);
        check_status(8'h06, "ovf_status_clr");
        wait_frames(base + 5, 400);
        if (starts.size() >= fd + 5)
            check(starts[fd+4] - starts[fd] == 160, "ovf_contig", starts[fd+4] - starts[fd], 160);
        else
            check(starts.size() >= fd + 5, "ovf_starts", starts.size(), fd + 5);
        check_status(8'h01, "ovf_status_end");

        // Full FIFO with a push on the STOP->START pop edge
        base = frames_done;
        fd = starts.size();
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hC2);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hC4);
        exp_q.push_back(8'hC5);
        exp_q.push_back(8'hC6);
        do_write(8'h0E, 8'hC1);
        do_write(8'h0E, 8'hC2);
        do_write(8'h0E, 8'hC3);
        do_write(8'h0E, 8'hC4);
        do_write(8'h0E, 8'hC5);
        check_status(8'h06, "coll_full_before");
        repeat (36) @(posedge clk);
        #1;
        do_write(8'h0E, 8'hC6);
        check(tx == 1'b0, "coll_restart_tx", int'(tx), 0);
        check_status(8'h06, "coll_status");
        wait_frames(base + 6, 400);
        if (starts.size() >= fd + 6)
            check(starts[fd+5] - starts[fd] == 200, "coll_contig", starts[fd+5] - starts[fd], 200);
        else
            check(starts.size() >= fd + 6, "coll_starts", starts.size(), fd + 6);
        check_status(8'h01, "coll_status_end");

        // Reset during DATA bit 3, with a byte still queued
        base = frames_done;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h77);
        do_write(8'h0E, 8'h5A);
        do_write(8'h0E, 8'h77);
        repeat (17) @(posedge clk);
        #1;
        reset   = 1'b1;
        exp_q.delete();
        address = 8'h0E;
        data_in = 8'h99;
        write   = 1'b1;
        @(posedge clk); #1;
        write   = 1'b0;
        reset   = 1'b0;
        check(tx == 1'b1, "rst_tx", int'(tx), 1);
        check(busy == 1'b0, "rst_busy", int'(busy), 0);
        check_status(8'h01, "rst_status");
        repeat (100) @(posedge clk);
        #1;
        check(frames_done == base, "rst_no_frame", frames_done, base);
        check(tx == 1'b1, "rst_tx_idle", int'(tx), 1);

        // Address decode
        address = 8'h0F; #1;
        check(rd_hit == 1'b1, "dec_0f_hit", int'(rd_hit), 1);
        address = 8'h0E; #1;
        check(rd_hit == 1'b1, "dec_0e_hit", int'(rd_hit), 1);
        check(data_out == 8'h00, "dec_0e_data", int'(data_out), 0);
        address = 8'h10; #1;
        check(rd_hit == 1'b0, "dec_10_hit", int'(rd_hit), 0);
        check(data_out == 8'h00, "dec_10_data", int'(data_out), 0);
        base = frames_done;
        address = 8'h0D;
        data_in = 8'h3C;
        write   = 1'b1;
        #1;
        check(rd_hit == 1'b0, "dec_0d_hit_wr", int'(rd_hit), 0);
        @(posedge clk); #1;
        write   = 1'b0;
        address = 8'h00;
        repeat (60) @(posedge clk);
        #1;
        check(busy == 1'b0, "dec_0d_busy", int'(busy), 0);
        check(frames_done == base, "dec_0d_noframe", frames_done, base);
        check_status(8'h01, "dec_status");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
